branch_resolve_unit: RTL and testbench

Execute-stage counterpart to the fetch-stage branch predictor. It holds each prediction issued at fetch in an in-order queue and checks it against the real outcome when the branch resolves in the ALU. It returns registered training feedback to the predictor. On a mispredict it drives a multi-cycle pipeline flush and a fetch redirect, and it keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_unit.sv | 204 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage partner of the fetch-stage branch predictor. Every prediction
// made at fetch is held in an in-order queue; when the oldest branch resolves
// in the ALU, the stored prediction is compared with the real direction.
// The unit returns registered training feedback to the predictor and, on a
// mispredict, raises a multi-cycle pipeline flush plus a one-cycle fetch
// redirect. Saturating branch / mispredict counters are kept for statistics.
//
// Ports
//   i_Clk, i_Reset        clock (rising edge), asynchronous active-high reset
//   i_IF_push             fetch issued a prediction this cycle
//   i_IF_pc               word address of the fetched branch
//   i_IF_prediction       predicted direction (1 = taken)
//   o_IF_stall            queue full, fetch must not push
//   i_ALU_valid           oldest in-flight branch resolves this cycle
//   i_ALU_taken           actual direction
//   i_ALU_target          computed taken target
//   o_BP_isbranch         one-cycle feedback strobe to the predictor
//   o_BP_outcome          actual direction of the resolved branch
//   o_BP_prediction       direction originally predicted
//   o_BP_pc               low GHR_SIZE bits of the resolved branch pc
//   o_flush               kill younger instructions in IF/ID/EX
//   o_redirect_valid      one-cycle fetch redirect strobe
//   o_redirect_pc         correct next fetch address
//   o_branch_count        resolved branches, saturating
//   o_mispredict_count    mispredicted branches, saturating
//   o_error               sticky: resolve seen with the queue empty
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int ADDRESS_WIDTH = 22,
   parameter int GHR_SIZE      = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int FLUSH_CYCLES  = 2,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic                     i_IF_push,
   input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
   input  logic                     i_IF_prediction,
   output logic                     o_IF_stall,
   input  logic                     i_ALU_valid,
   input  logic                     i_ALU_taken,
   input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
   output logic                     o_BP_isbranch,
   output logic                     o_BP_outcome,
   output logic                     o_BP_prediction,
   output logic [GHR_SIZE-1:0]      o_BP_pc,
   output logic                     o_flush,
   output logic                     o_redirect_valid,
   output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
   output logic [CNT_WIDTH-1:0]     o_branch_count,
   output logic [CNT_WIDTH-1:0]     o_mispredict_count,
   output logic                     o_error
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int FCW   = $clog2(FLUSH_CYCLES + 1);

   localparam logic [PTR_W-1:0]         PTR_ONE   = 1;
   localparam logic [OCC_W-1:0]         OCC_ONE   = 1;
   localparam logic [OCC_W-1:0]         OCC_FULL  = OCC_W'(FIFO_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = 1;
   localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = 1;
   localparam logic [FCW-1:0]           FCNT_ONE  = 1;
   localparam logic [FCW-1:0]           FCNT_LOAD = FCW'(FLUSH_CYCLES - 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t                   state, state_next;
   logic [FCW-1:0]           flush_cnt, flush_cnt_next;

   logic [ADDRESS_WIDTH-1:0] pc_mem   [0:FIFO_DEPTH-1];
   logic                     pred_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [OCC_W-1:0]         occ;

   logic                     running, full, empty;
   logic                     push, pop, mispredict;
   logic [ADDRESS_WIDTH-1:0] head_pc;
   logic                     head_pred;

   assign running    = (state == RUN);
   assign full       = (occ == OCC_FULL);
   assign empty      = (occ == '0);
   assign o_IF_stall = full;
   assign o_flush    = (state == FLUSH);

   // A push into a full queue is refused even when a pop frees a slot in the
   // same cycle: fetch sees o_IF_stall=1 and will replay that branch.
   assign push       = i_IF_push && !full && running;
   assign pop        = i_ALU_valid && !empty && running;
   assign head_pc    = pc_mem[rd_ptr];
   assign head_pred  = pred_mem[rd_ptr];
   assign mispredict = pop && (i_ALU_taken != head_pred);

   // -------------------------------------------------------------------------
   // Flush FSM
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      case (state)
         RUN: begin
            if (mispredict) begin
               state_next     = FLUSH;
               flush_cnt_next = FCNT_LOAD;
            end
         end
         FLUSH: begin
            if (flush_cnt == '0) state_next = RUN;
            else                 flush_cnt_next = flush_cnt - FCNT_ONE;
         end
         default: state_next = RUN;
      endcase
   end

   // -------------------------------------------------------------------------
   // Prediction queue
   // -------------------------------------------------------------------------
   // NOTE: the storage array is not reset; an entry is only read after it has
   // been written, and pointers/occupancy alone define what is valid.
   always_ff @(posedge i_Clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= i_IF_pc;
         pred_mem[wr_ptr] <= i_IF_prediction;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (mispredict) begin
         // Everything behind the mispredicted branch, including a push in
         // this same cycle, is on the wrong path.
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Feedback, redirect, statistics
   // -------------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         o_BP_isbranch      <= 1'b0;
         o_BP_outcome       <= 1'b0;
         o_BP_prediction    <= 1'b0;
         o_BP_pc            <= '0;
         o_redirect_valid   <= 1'b0;
         o_redirect_pc      <= '0;
         o_branch_count     <= '0;
         o_mispredict_count <= '0;
         o_error            <= 1'b0;
      end else begin
         o_BP_isbranch    <= pop;
         o_redirect_valid <= mispredict;
         if (pop) begin
            o_BP_outcome    <= i_ALU_taken;
            o_BP_prediction <= head_pred;
            o_BP_pc         <= head_pc[GHR_SIZE-1:0];
            if (o_branch_count != '1) o_branch_count <= o_branch_count + CNT_ONE;
         end
         if (mispredict) begin
            o_redirect_pc <= i_ALU_taken ? i_ALU_target : head_pc + ADDR_ONE;
            if (o_mispredict_count != '1)
               o_mispredict_count <= o_mispredict_count + CNT_ONE;
         end
         if (i_ALU_valid && empty && running) o_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   localparam int AW    = 22;
   localparam int GW    = 8;
   localparam int DEPTH = 4;
   localparam int FC    = 2;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic          pred;
   } entry_t;

   typedef struct packed {
      logic [GW-1:0] pc;
      logic          outcome;
      logic          pred;
      logic          mis;
      logic [AW-1:0] rpc;
   } fb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_IF_push = 1'b0;
   logic [AW-1:0] i_IF_pc = '0;
   logic          i_IF_prediction = 1'b0;
   logic          i_ALU_valid = 1'b0;
   logic          i_ALU_taken = 1'b0;
   logic [AW-1:0] i_ALU_target = '0;

   logic          o_IF_stall, o_BP_isbranch, o_BP_outcome, o_BP_prediction;
   logic [GW-1:0] o_BP_pc;
   logic          o_flush, o_redirect_valid, o_error;
   logic [AW-1:0] o_redirect_pc;
   logic [31:0]   o_branch_count, o_mispredict_count;

   logic          s_stall, s_isbranch, s_outcome, s_prediction;
   logic [GW-1:0] s_bp_pc;
   logic          s_flush, s_redirect_valid, s_error;
   logic [AW-1:0] s_redirect_pc;
   logic [3:0]    s_branch_count, s_mispredict_count;

   int     compared   = 0;
   int     mismatched = 0;
   entry_t model_q[$];
   fb_t    sb_q[$];
   int     flush_left = 0;
   int     exp_br     = 0;
   int     exp_mis    = 0;
   bit     exp_err    = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.ADDRESS_WIDTH(AW), .GHR_SIZE(GW), .FIFO_DEPTH(DEPTH),
                         .FLUSH_CYCLES(FC), .CNT_WIDTH(32)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_IF_push(i_IF_push), .i_IF_pc(i_IF_pc), .i_IF_prediction(i_IF_prediction),
      .o_IF_stall(o_IF_stall),
      .i_ALU_valid(i_ALU_valid), .i_ALU_taken(i_ALU_taken), .i_ALU_target(i_ALU_target),
      .o_BP_isbranch(o_BP_isbranch), .o_BP_outcome(o_BP_outcome),
      .o_BP_prediction(o_BP_prediction), .o_BP_pc(o_BP_pc),
      .o_flush(o_flush), .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count),
      .o_error(o_error)
   );

   // Narrow-counter copy sharing all stimulus, used for saturation.
   branch_resolve_unit #(.ADDRESS_WIDTH(AW), .GHR_SIZE(GW), .FIFO_DEPTH(DEPTH),
                         .FLUSH_CYCLES(FC), .CNT_WIDTH(4)) dut4 (
      .i_Clk(clk), .i_Reset(rst),
      .i_IF_push(i_IF_push), .i_IF_pc(i_IF_pc), .i_IF_prediction(i_IF_prediction),
      .o_IF_stall(s_stall),
      .i_ALU_valid(i_ALU_valid), .i_ALU_taken(i_ALU_taken), .i_ALU_target(i_ALU_target),
      .o_BP_isbranch(s_isbranch), .o_BP_outcome(s_outcome),
      .o_BP_prediction(s_prediction), .o_BP_pc(s_bp_pc),
      .o_flush(s_flush), .o_redirect_valid(s_redirect_valid), .o_redirect_pc(s_redirect_pc),
      .o_branch_count(s_branch_count), .o_mispredict_count(s_mispredict_count),
      .o_error(s_error)
   );

   // Scoreboard / per-cycle monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         fb_t f;
         if (o_BP_isbranch) begin
            compared++;
            if (sb_q.size() == 0) begin
               mismatched++;
               $display("FAIL feedback_unexpected: got pc=%h with no expected entry", o_BP_pc);
            end else begin
               f = sb_q.pop_front();
               if ({o_BP_pc, o_BP_outcome, o_BP_prediction} !== {f.pc, f.outcome, f.pred}) begin
                  mismatched++;
                  $display("FAIL feedback: got pc=%h out=%b pred=%b, want pc=%h out=%b pred=%b",
                           o_BP_pc, o_BP_outcome, o_BP_prediction, f.pc, f.outcome, f.pred);
               end
               compared++;
               if (o_redirect_valid !== f.mis || (f.mis && o_redirect_pc !== f.rpc)) begin
                  mismatched++;
                  $display("FAIL redirect: got valid=%b pc=%h, want valid=%b pc=%h",
                           o_redirect_valid, o_redirect_pc, f.mis, f.rpc);
               end
            end
         end else begin
            compared++;
            if (o_redirect_valid !== 1'b0) begin
               mismatched++;
               $display("FAIL redirect_idle: got valid=%b, want 0", o_redirect_valid);
            end
         end
         compared++;
         if (o_flush !== (flush_left > 0)) begin
            mismatched++;
            $display("FAIL flush: got %b, want %b", o_flush, flush_left > 0);
         end
         compared++;
         if (o_error !== exp_err) begin
            mismatched++;
            $display("FAIL error: got %b, want %b", o_error, exp_err);
         end
         compared++;
         if (o_branch_count !== 32'(exp_br) || o_mispredict_count !== 32'(exp_mis)) begin
            mismatched++;
            $display("FAIL counts: got br=%0d mis=%0d, want br=%0d mis=%0d",
                     o_branch_count, o_mispredict_count, exp_br, exp_mis);
         end
      end
   end

   // Drives one full clock cycle of stimulus (entered and left at posedge+1)
   // and advances the reference model accordingly.
   task automatic do_cycle(input logic push, input logic [AW-1:0] pc, input logic pred,
                           input logic valid, input logic taken, input logic [AW-1:0] target);
      entry_t e;
      fb_t    f;
      bit     have_fb  = 1'b0;
      bit     mis_now  = 1'b0;
      bit     err_now  = 1'b0;
      bit     flushing = (flush_left > 0);
      bit     stalled  = (model_q.size() == DEPTH);
      i_IF_push = push; i_IF_pc = pc; i_IF_prediction = pred;
      i_ALU_valid = valid; i_ALU_taken = taken; i_ALU_target = target;
      if (valid && !flushing) begin
         if (model_q.size() != 0) begin
            e       = model_q.pop_front();
            mis_now = (taken != e.pred);
            f.pc      = e.pc[GW-1:0];
            f.outcome = taken;
            f.pred    = e.pred;
            f.mis     = mis_now;
            f.rpc     = taken ? target : e.pc + 22'd1;
            have_fb   = 1'b1;
            if (mis_now) model_q.delete();
         end else begin
            err_now = 1'b1;
         end
      end
      if (push && !flushing && !stalled && !mis_now) model_q.push_back('{pc: pc, pred: pred});
      @(posedge clk); #1;
      i_IF_push = 1'b0; i_ALU_valid = 1'b0;
      if (flushing) flush_left--;
      if (mis_now)  flush_left = FC;
      if (have_fb) begin
         sb_q.push_back(f);
         exp_br++;
         if (mis_now) exp_mis++;
      end
      if (err_now) exp_err = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      i_IF_push = 1'b0; i_ALU_valid = 1'b0;
      model_q.delete(); sb_q.delete();
      flush_left = 0; exp_br = 0; exp_mis = 0; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      compared++;
      if ({o_BP_isbranch, o_BP_outcome, o_BP_prediction, o_BP_pc, o_flush,
           o_redirect_valid, o_redirect_pc, o_error, o_IF_stall} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: isb=%b flush=%b rv=%b rpc=%h err=%b stall=%b, want all 0",
                  o_BP_isbranch, o_flush, o_redirect_valid, o_redirect_pc, o_error, o_IF_stall);
      end
      compared++;
      if (o_branch_count !== 32'd0 || o_mispredict_count !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_counts: got br=%0d mis=%0d, want 0/0", o_branch_count, o_mispredict_count);
      end
      apply_reset();
   endtask

   task automatic test_correct();
      do_cycle(1'b1, 22'h10, 1'b1, 1'b0, 1'b0, '0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 22'h99);
      compared++;
      if (o_BP_isbranch !== 1'b1 || o_BP_pc !== 8'h10 || o_flush !== 1'b0) begin
         mismatched++;
         $display("FAIL correct_pred: got isb=%b pc=%h flush=%b, want 1/10/0",
                  o_BP_isbranch, o_BP_pc, o_flush);
      end
      compared++;
      if (o_branch_count !== 32'd1 || o_mispredict_count !== 32'd0) begin
         mismatched++;
         $display("FAIL correct_counts: got br=%0d mis=%0d, want 1/0", o_branch_count, o_mispredict_count);
      end
      idle(1);
   endtask

   task automatic test_mispredict_taken();
      do_cycle(1'b1, 22'h20, 1'b0, 1'b0, 1'b0, '0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 22'h40);
      compared++;
      if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 22'h40 || o_flush !== 1'b1
          || o_mispredict_count !== 32'd1) begin
         mismatched++;
         $display("FAIL mispredict_taken: got rv=%b rpc=%h flush=%b mis=%0d, want 1/40/1/1",
                  o_redirect_valid, o_redirect_pc, o_flush, o_mispredict_count);
      end
      // Pushes during the flush must be ignored.
      do_cycle(1'b1, 22'h50, 1'b1, 1'b0, 1'b0, '0);
      compared++;
      if (o_flush !== 1'b1 || o_redirect_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_second_cycle: got flush=%b rv=%b, want 1/0", o_flush, o_redirect_valid);
      end
      do_cycle(1'b1, 22'h60, 1'b1, 1'b0, 1'b0, '0);
      compared++;
      if (o_flush !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_end: got flush=%b, want 0", o_flush);
      end
   endtask

   task automatic test_mispredict_not_taken();
      int hi = 0;
      do_cycle(1'b1, 22'h30, 1'b1, 1'b0, 1'b0, '0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 22'h77);
      compared++;
      if (o_BP_pc !== 8'h30 || o_redirect_pc !== 22'h31 || o_redirect_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL mispredict_not_taken: got pc=%h rpc=%h rv=%b, want 30/31/1",
                  o_BP_pc, o_redirect_pc, o_redirect_valid);
      end
      for (int i = 0; i < 8 && o_flush; i++) begin
         hi++;
         idle(1);
      end
      compared++;
      if (hi != FC) begin
         mismatched++;
         $display("FAIL flush_length: got %0d cycles, want %0d", hi, FC);
      end
   endtask

   task automatic test_full_and_back_to_back();
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 22'h100 + AW'(i), 1'b1, 1'b0, 1'b0, '0);
      compared++;
      if (o_IF_stall !== 1'b1) begin
         mismatched++;
         $display("FAIL stall_full: got %b, want 1", o_IF_stall);
      end
      do_cycle(1'b1, 22'h104, 1'b0, 1'b0, 1'b0, '0);
      compared++;
      if (o_IF_stall !== 1'b1) begin
         mismatched++;
         $display("FAIL stall_after_drop: got %b, want 1", o_IF_stall);
      end
      // Push and pop together while full, then resolve back to back.
      do_cycle(1'b1, 22'h105, 1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, '0);
      compared++;
      if (o_IF_stall !== 1'b0 || o_branch_count !== 32'(exp_br)) begin
         mismatched++;
         $display("FAIL back_to_back: got stall=%b br=%0d, want 0/%0d", o_IF_stall, o_branch_count, exp_br);
      end
      idle(1);
   endtask

   task automatic test_error_and_async_reset();
      apply_reset();
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 22'h5);
      compared++;
      if (o_error !== 1'b1 || o_BP_isbranch !== 1'b0 || o_branch_count !== 32'd0) begin
         mismatched++;
         $display("FAIL empty_resolve: got err=%b isb=%b br=%0d, want 1/0/0",
                  o_error, o_BP_isbranch, o_branch_count);
      end
      do_cycle(1'b1, 22'h70, 1'b0, 1'b0, 1'b0, '0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 22'h80);
      compared++;
      if (o_flush !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_reset_flush: got %b, want 1", o_flush);
      end
      #2 rst = 1'b1;
      model_q.delete(); sb_q.delete();
      flush_left = 0; exp_br = 0; exp_mis = 0; exp_err = 1'b0;
      #1;
      compared++;
      if ({o_flush, o_redirect_valid, o_BP_isbranch, o_error, o_redirect_pc} !== '0
          || o_branch_count !== 32'd0 || o_mispredict_count !== 32'd0) begin
         mismatched++;
         $display("FAIL async_reset: got flush=%b rv=%b isb=%b err=%b br=%0d mis=%0d, want all 0",
                  o_flush, o_redirect_valid, o_BP_isbranch, o_error, o_branch_count, o_mispredict_count);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         do_cycle(1'b1, AW'(i), 1'b1, 1'b0, 1'b0, '0);
         do_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
         idle(FC);
      end
      compared++;
      if (s_branch_count !== 4'd15 || s_mispredict_count !== 4'd15) begin
         mismatched++;
         $display("FAIL saturate: got br=%0d mis=%0d, want 15/15", s_branch_count, s_mispredict_count);
      end
      compared++;
      if (o_branch_count !== 32'd20 || o_mispredict_count !== 32'd20) begin
         mismatched++;
         $display("FAIL wide_counts: got br=%0d mis=%0d, want 20/20", o_branch_count, o_mispredict_count);
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_mispredict_taken();
      test_mispredict_not_taken();
      test_full_and_back_to_back();
      test_error_and_async_reset();
      test_saturate();
      idle(2);
      compared++;
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: %0d expected feedback entries never seen, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
